// File: rtl/lsu_mem_initiator.sv
// RV32 load/store initiator towards a word-wide, byte-enabled data memory.
// Define LSU_MISALIGN_EN to split misaligned accesses into two word beats.
module lsu_mem_initiator #(
   parameter int ADDR_W = 13
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [2:0]        req_funct3_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [31:0]       req_wdata_i,
   output logic              rsp_valid_o,
   output logic [31:0]       rsp_rdata_o,
   output logic              rsp_err_o,
   output logic              mem_req_o,
   input  logic              mem_gnt_i,
   output logic              mem_we_o,
   output logic [ADDR_W-3:0] mem_addr_o,
   output logic [3:0]        mem_be_o,
   output logic [31:0]       mem_wdata_o,
   input  logic              mem_rvalid_i,
   input  logic [31:0]       mem_rdata_i
);
   localparam int WA_W = ADDR_W - 2;
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_REQ0  = 3'd1;
   localparam logic [2:0] S_WAIT0 = 3'd2;
   localparam logic [2:0] S_RESP  = 3'd5;
`ifdef LSU_MISALIGN_EN
   localparam logic [2:0] S_REQ1  = 3'd3;
   localparam logic [2:0] S_WAIT1 = 3'd4;
   localparam int BUF_W = 64;
`else
   localparam int BUF_W = 32;
`endif
   localparam int BE_W = BUF_W / 8;

   logic [2:0]       r_state;
   logic [2:0]       w_state_next;
   logic             r_we;
   logic [2:0]       r_funct3;
   logic [1:0]       r_off;
   logic             r_err;
   logic [BUF_W-1:0] r_buf;
`ifdef LSU_MISALIGN_EN
   logic             r_split;
   logic [3:0]       r_be1;
   logic [31:0]      r_wdata1;
   logic             w_to_req1;
`endif

   logic             w_accept;
   logic             w_legal;
   logic             w_misalign;
   logic             w_err;
   logic [1:0]       w_off;
   logic [2:0]       w_size;
   logic [3:0]       w_mask;
   logic [BUF_W-1:0] w_wide;
   logic [BE_W-1:0]  w_be;
   logic [31:0]      w_lo;
   logic [31:0]      w_ext;

   assign req_ready_o = (r_state == S_IDLE);
   assign w_accept    = req_valid_i && req_ready_o;
   assign w_off       = req_addr_i[1:0];

   always_comb begin
      w_size = 3'd4;
      w_mask = 4'hF;
      case (req_funct3_i[1:0])
         2'd0: begin
            w_size = 3'd1;
            w_mask = 4'h1;
         end
         2'd1: begin
            w_size = 3'd2;
            w_mask = 4'h3;
         end
         default: ;
      endcase
   end

   // Loads allow 0,1,2,4,5; stores allow 0,1,2.
   assign w_legal = req_we_i ? (req_funct3_i <= 3'd2)
                             : ((req_funct3_i != 3'd3) && (req_funct3_i[2:1] != 2'b11));
   assign w_misalign = ({1'b0, w_off} + w_size) > 3'd4;
`ifdef LSU_MISALIGN_EN
   assign w_err = !w_legal;
`else
   assign w_err = !w_legal || w_misalign;
`endif

   // Upper half of the shifted data/lane mask belongs to the second beat.
   assign w_wide = BUF_W'(req_wdata_i) << {w_off, 3'b000};
   assign w_be   = BE_W'(w_mask) << w_off;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_state_next = w_err ? S_RESP : S_REQ0;
         end
         S_REQ0: begin
            if (mem_gnt_i) begin
               if (!r_we) w_state_next = S_WAIT0;
`ifdef LSU_MISALIGN_EN
               else if (r_split) w_state_next = S_REQ1;
`endif
               else w_state_next = S_RESP;
            end
         end
         S_WAIT0: begin
`ifdef LSU_MISALIGN_EN
            if (mem_rvalid_i) w_state_next = r_split ? S_REQ1 : S_RESP;
`else
            if (mem_rvalid_i) w_state_next = S_RESP;
`endif
         end
`ifdef LSU_MISALIGN_EN
         S_REQ1: begin
            if (mem_gnt_i) w_state_next = r_we ? S_RESP : S_WAIT1;
         end
         S_WAIT1: begin
            if (mem_rvalid_i) w_state_next = S_RESP;
         end
`endif
         S_RESP:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

`ifdef LSU_MISALIGN_EN
   assign w_to_req1 = (w_state_next == S_REQ1) && (r_state != S_REQ1);
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= S_IDLE;
         r_we        <= 1'b0;
         r_funct3    <= 3'd0;
         r_off       <= 2'd0;
         r_err       <= 1'b0;
         r_buf       <= '0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_be_o    <= 4'h0;
         mem_wdata_o <= 32'h0;
`ifdef LSU_MISALIGN_EN
         r_split     <= 1'b0;
         r_be1       <= 4'h0;
         r_wdata1    <= 32'h0;
`endif
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_we        <= req_we_i;
            r_funct3    <= req_funct3_i;
            r_off       <= w_off;
            r_err       <= w_err;
            r_buf       <= '0;
            mem_we_o    <= req_we_i;
            mem_addr_o  <= req_addr_i[ADDR_W-1:2];
            mem_be_o    <= w_be[3:0];
            mem_wdata_o <= w_wide[31:0];
`ifdef LSU_MISALIGN_EN
            r_split     <= w_misalign;
            r_be1       <= w_be[7:4];
            r_wdata1    <= w_wide[63:32];
`endif
         end
         if ((r_state == S_WAIT0) && mem_rvalid_i) r_buf[31:0] <= mem_rdata_i;
`ifdef LSU_MISALIGN_EN
         // Word address wraps naturally at the top of memory.
         if (w_to_req1) begin
            mem_addr_o  <= mem_addr_o + WA_W'(1);
            mem_be_o    <= r_be1;
            mem_wdata_o <= r_wdata1;
         end
         if ((r_state == S_WAIT1) && mem_rvalid_i) r_buf[63:32] <= mem_rdata_i;
`endif
      end
   end

   assign mem_req_o = (r_state == S_REQ0)
`ifdef LSU_MISALIGN_EN
                   || (r_state == S_REQ1)
`endif
                   ;

   assign w_lo = 32'(r_buf >> {r_off, 3'b000});

   always_comb begin
      w_ext = w_lo;
      case (r_funct3)
         3'd0:    w_ext = {{24{w_lo[7]}}, w_lo[7:0]};
         3'd1:    w_ext = {{16{w_lo[15]}}, w_lo[15:0]};
         3'd4:    w_ext = {24'h0, w_lo[7:0]};
         3'd5:    w_ext = {16'h0, w_lo[15:0]};
         default: w_ext = w_lo;
      endcase
   end

   assign rsp_valid_o = (r_state == S_RESP);
   assign rsp_err_o   = rsp_valid_o && r_err;
   assign rsp_rdata_o = (rsp_valid_o && !r_we && !r_err) ? w_ext : 32'h0;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Bench for lsu_mem_initiator: byte-level reference model, memory responder
// with random wait states, directed literal cases and a randomized run.
module tb_lsu_mem_initiator;
   localparam int ADDR_W = 13;
   localparam int NWORDS = 1 << (ADDR_W - 2);
   localparam int NBYTES = 1 << ADDR_W;

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic              req_valid_i;
   logic              req_ready_o;
   logic              req_we_i;
   logic [2:0]        req_funct3_i;
   logic [ADDR_W-1:0] req_addr_i;
   logic [31:0]       req_wdata_i;
   logic              rsp_valid_o;
   logic [31:0]       rsp_rdata_o;
   logic              rsp_err_o;
   logic              mem_req_o;
   logic              mem_gnt_i;
   logic              mem_we_o;
   logic [ADDR_W-3:0] mem_addr_o;
   logic [3:0]        mem_be_o;
   logic [31:0]       mem_wdata_o;
   logic              mem_rvalid_i;
   logic [31:0]       mem_rdata_i;

   always #5 clk_i = ~clk_i;

   lsu_mem_initiator #(.ADDR_W(ADDR_W)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
      .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
      .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   logic [31:0] mem       [NWORDS];
   logic [7:0]  ref_bytes [NBYTES];

   // expected beats and responses (ring buffers)
   logic [ADDR_W-3:0] eb_addr [256];
   logic [3:0]        eb_be   [256];
   logic              eb_we   [256];
   logic [31:0]       eb_data [256];
   int                beat_wr = 0, beat_rd = 0;
   logic              er_err  [256];
   logic [31:0]       er_data [256];
   int                rsp_wr = 0, rsp_rd = 0;

   logic [ADDR_W-3:0] cap_addr [2];
   logic [3:0]        cap_be   [2];
   logic [31:0]       cap_data [2];
   int                cap_n = 0;
   logic [31:0]       last_rdata;
   logic              last_err;
   int                acc_cyc = 0, rsp_cyc = 0, rsp_seen = 0, req_cycles = 0;

   int                gnt_dly = 0, rv_dly = 0, gnt_cnt = 0, rd_cnt = 0;
   bit                stray_en = 0, req_seen = 0, rd_pend = 0;
   logic [ADDR_W-3:0] rd_word;
   bit                g_valid = 0, g_we = 0;
   logic [ADDR_W-3:0] g_addr;
   logic [3:0]        g_be;
   logic [31:0]       g_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h required %08h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic fail_line(input string name);
      n_checks++;
      $display("FAIL %s: event not as required (cycle %0d)", name, cyc);
   endtask

   task automatic set_word(input int w, input logic [31:0] v);
      mem[w] = v;
      for (int l = 0; l < 4; l++) ref_bytes[4*w+l] = v[8*l+:8];
   endtask

   task automatic push_beat(input int w, input logic [3:0] be, input logic we, input logic [31:0] d);
      eb_addr[beat_wr % 256] = (ADDR_W-2)'(w);
      eb_be[beat_wr % 256]   = be;
      eb_we[beat_wr % 256]   = we;
      eb_data[beat_wr % 256] = d;
      beat_wr++;
   endtask

   task automatic push_rsp(input logic err, input logic [31:0] d);
      er_err[rsp_wr % 256]  = err;
      er_data[rsp_wr % 256] = d;
      rsp_wr++;
   endtask

   // Reference: works on a byte-addressed view of memory
   task automatic model(input logic we, input logic [2:0] f3, input logic [ADDR_W-1:0] addr,
                        input logic [31:0] wd);
      int size, off, ba, lane, a;
      logic legal, mis, err;
      logic [63:0] wide;
      logic [3:0] be0, be1;
      logic [31:0] v;
      a     = int'(addr);
      size  = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
      off   = a % 4;
      legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      mis   = (off + size) > 4;
`ifdef LSU_MISALIGN_EN
      err = !legal;
`else
      err = !legal || mis;
`endif
      if (err) begin
         push_rsp(1'b1, 32'h0);
         return;
      end
      wide = {32'h0, wd} << (8 * off);
      be0 = 4'h0;
      be1 = 4'h0;
      for (int i = 0; i < size; i++) begin
         lane = off + i;
         if (lane < 4) be0[lane] = 1'b1;
         else be1[lane-4] = 1'b1;
      end
      push_beat(a / 4, be0, we, wide[31:0]);
      if (mis) push_beat((a / 4 + 1) % NWORDS, be1, we, wide[63:32]);
      v = 32'h0;
      for (int i = 0; i < size; i++) begin
         ba = (a + i) % NBYTES;
         if (we) ref_bytes[ba] = wd[8*i+:8];
         else v[8*i+:8] = ref_bytes[ba];
      end
      if (!we) begin
         case (f3)
            3'd0: v = {{24{v[7]}}, v[7:0]};
            3'd1: v = {{16{v[15]}}, v[15:0]};
            default: ;
         endcase
      end
      push_rsp(1'b0, we ? 32'h0 : v);
   endtask

   // compare process: runs every negedge through tick()
   task automatic monitor();
      int k;
      g_valid = 0;
      if (!rst_ni) begin
         beat_rd = beat_wr;
         rsp_rd  = rsp_wr;
         return;
      end
      if (mem_req_o) begin
         req_cycles++;
         if (beat_rd == beat_wr) fail_line("unexpected_mem_req");
         else begin
            k = beat_rd % 256;
            chk("mem_addr", 32'(mem_addr_o), 32'(eb_addr[k]));
            chk("mem_be", 32'(mem_be_o), 32'(eb_be[k]));
            chk("mem_we", 32'(mem_we_o), 32'(eb_we[k]));
            if (eb_we[k]) chk("mem_wdata", mem_wdata_o, eb_data[k]);
            if (mem_gnt_i) begin
               g_valid = 1;
               g_we    = mem_we_o;
               g_addr  = mem_addr_o;
               g_be    = mem_be_o;
               g_data  = mem_wdata_o;
               if (cap_n < 2) begin
                  cap_addr[cap_n] = mem_addr_o;
                  cap_be[cap_n]   = mem_be_o;
                  cap_data[cap_n] = mem_wdata_o;
               end
               cap_n++;
               beat_rd++;
            end
         end
      end
      if (rsp_valid_o) begin
         if (rsp_rd == rsp_wr) fail_line("unexpected_rsp");
         else begin
            k = rsp_rd % 256;
            chk("beats_issued", 32'(beat_rd), 32'(beat_wr));
            chk("rsp_err", 32'(rsp_err_o), 32'(er_err[k]));
            chk("rsp_rdata", rsp_rdata_o, er_data[k]);
            rsp_rd++;
         end
         last_rdata = rsp_rdata_o;
         last_err   = rsp_err_o;
         rsp_cyc    = cyc;
         rsp_seen++;
         $display("txn %0d: err=%0b rdata=%08h beats=%0d latency=%0d",
                  rsp_seen, rsp_err_o, rsp_rdata_o, cap_n, cyc - acc_cyc);
      end
   endtask

   task automatic responder();
      if (g_valid) begin
         if (g_we) begin
            for (int l = 0; l < 4; l++) if (g_be[l]) mem[g_addr][8*l+:8] = g_data[8*l+:8];
         end else begin
            rd_pend = 1;
            rd_word = g_addr;
            rd_cnt  = rv_dly;
         end
      end
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = $urandom;
      if (rd_pend) begin
         if (rd_cnt == 0) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = mem[rd_word];
            rd_pend      = 0;
         end else rd_cnt--;
      end else if (stray_en && ($urandom_range(0, 7) == 0)) mem_rvalid_i = 1'b1;
      mem_gnt_i = 1'b0;
      if (mem_req_o) begin
         if (!req_seen) begin
            req_seen = 1;
            gnt_cnt  = gnt_dly;
         end
         if (gnt_cnt == 0) begin
            mem_gnt_i = 1'b1;
            req_seen  = 0;
         end else gnt_cnt--;
      end else req_seen = 0;
   endtask

   task automatic tick();
      @(negedge clk_i);
      monitor();
      @(posedge clk_i);
      cyc++;
      #1;
      responder();
   endtask

   task automatic do_req(input logic we, input logic [2:0] f3, input logic [ADDR_W-1:0] addr,
                         input logic [31:0] wd);
      int n = 0;
      while (!req_ready_o && n < 100) begin
         tick();
         n++;
      end
      if (!req_ready_o) begin
         fail_line("req_ready_timeout");
         return;
      end
      model(we, f3, addr, wd);
      cap_n        = 0;
      req_valid_i  = 1'b1;
      req_we_i     = we;
      req_funct3_i = f3;
      req_addr_i   = addr;
      req_wdata_i  = wd;
      acc_cyc      = cyc;
      tick();
      req_valid_i  = 1'b0;
      req_we_i     = 1'($urandom);
      req_funct3_i = 3'($urandom);
      req_addr_i   = ADDR_W'($urandom);
      req_wdata_i  = $urandom;
   endtask

   task automatic wait_done();
      int n = 0;
      while (rsp_rd != rsp_wr && n < 200) begin
         tick();
         n++;
      end
      if (rsp_rd != rsp_wr) fail_line("rsp_timeout");
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'h0);
      chk({tag, "_rsp_rdata"}, rsp_rdata_o, 32'h0);
      chk({tag, "_rsp_err"}, 32'(rsp_err_o), 32'h0);
      chk({tag, "_mem_req"}, 32'(mem_req_o), 32'h0);
      chk({tag, "_mem_we"}, 32'(mem_we_o), 32'h0);
      chk({tag, "_mem_be"}, 32'(mem_be_o), 32'h0);
      chk({tag, "_mem_addr"}, 32'(mem_addr_o), 32'h0);
      chk({tag, "_mem_wdata"}, mem_wdata_o, 32'h0);
      chk({tag, "_req_ready"}, 32'(req_ready_o), 32'h1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, saved_rsp, saved_req;
      logic we;
      logic [2:0] f3;
      logic [ADDR_W-1:0] addr;
      rst_ni = 1'b0;
      req_valid_i = 1'b0; req_we_i = 1'b0; req_funct3_i = 3'd0;
      req_addr_i = '0; req_wdata_i = 32'h0;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
      for (int w = 0; w < NWORDS; w++) set_word(w, $urandom);
      repeat (2) @(posedge clk_i);
      #1;
      check_reset_vals("rst");
      tick();
      rst_ni = 1'b1;
      tick();

      // aligned LW, zero-wait memory
      set_word(4, 32'h8899AABB);
      do_req(1'b0, 3'd2, 13'h010, 32'h0);
      wait_done();
      chk("lw_be", 32'(cap_be[0]), 32'hF);
      chk("lw_addr", 32'(cap_addr[0]), 32'h4);
      chk("lw_rdata", last_rdata, 32'h8899AABB);
      chk("lw_latency", 32'(rsp_cyc - acc_cyc), 32'd3);

      // SB into the top lane
      do_req(1'b1, 3'd0, 13'h013, 32'h123456A5);
      wait_done();
      chk("sb_beats", 32'(cap_n), 32'd1);
      chk("sb_be", 32'(cap_be[0]), 32'h8);
      chk("sb_wdata", cap_data[0], 32'hA5000000);
      chk("sb_err", 32'(last_err), 32'h0);
      chk("sb_latency", 32'(rsp_cyc - acc_cyc), 32'd2);

      // illegal load funct3
      saved_req = req_cycles;
      do_req(1'b0, 3'd3, 13'h040, 32'h0);
      wait_done();
      chk("ill_err", 32'(last_err), 32'h1);
      chk("ill_latency", 32'(rsp_cyc - acc_cyc), 32'd1);
      chk("ill_no_traffic", 32'(req_cycles - saved_req), 32'd0);

`ifdef LSU_MISALIGN_EN
      set_word(1, 32'h80FFFFFF);
      set_word(2, 32'h00000012);
      do_req(1'b0, 3'd1, 13'h007, 32'h0);
      wait_done();
      chk("lh_be0", 32'(cap_be[0]), 32'h8);
      chk("lh_be1", 32'(cap_be[1]), 32'h1);
      chk("lh_rdata", last_rdata, 32'h00001280);
      chk("lh_latency", 32'(rsp_cyc - acc_cyc), 32'd5);

      do_req(1'b1, 3'd2, 13'h1FFE, 32'hDEADBEEF);
      wait_done();
      chk("sw_addr0", 32'(cap_addr[0]), 32'h7FF);
      chk("sw_be0", 32'(cap_be[0]), 32'hC);
      chk("sw_data0", cap_data[0], 32'hBEEF0000);
      chk("sw_addr1", 32'(cap_addr[1]), 32'h000);
      chk("sw_be1", 32'(cap_be[1]), 32'h3);
      chk("sw_data1", cap_data[1], 32'h0000DEAD);
      chk("sw_latency", 32'(rsp_cyc - acc_cyc), 32'd3);
`else
      saved_req = req_cycles;
      do_req(1'b0, 3'd2, 13'h001, 32'h0);
      wait_done();
      chk("mis_err", 32'(last_err), 32'h1);
      chk("mis_latency", 32'(rsp_cyc - acc_cyc), 32'd1);
      chk("mis_no_traffic", 32'(req_cycles - saved_req), 32'd0);
      do_req(1'b1, 3'd2, 13'h1FFE, 32'hDEADBEEF);
      wait_done();
      chk("sw_wrap_err", 32'(last_err), 32'h1);
`endif

      // delayed grant, then reset pulse while waiting for read data
      gnt_dly = 3;
      rv_dly  = 6;
      do_req(1'b0, 3'd2, 13'h020, 32'h0);
      n = 0;
      while (cap_n == 0 && n < 50) begin
         tick();
         n++;
      end
      if (cap_n == 0) fail_line("grant_timeout");
      chk("gnt_wait", 32'(cyc - acc_cyc), 32'd5);
      rst_ni = 1'b0;
      #1;
      check_reset_vals("midrst");
      tick();
      rst_ni = 1'b1;
      saved_rsp = rsp_seen;
      saved_req = req_cycles;
      repeat (12) tick();
      chk("late_rvalid_no_rsp", 32'(rsp_seen - saved_rsp), 32'd0);
      chk("late_rvalid_no_req", 32'(req_cycles - saved_req), 32'd0);

      // randomized traffic
      stray_en = 1;
      for (int t = 0; t < 300; t++) begin
         gnt_dly = $urandom_range(0, 2);
         rv_dly  = $urandom_range(0, 2);
         we      = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
         else if (we) f3 = 3'($urandom_range(0, 2));
         else begin
            case ($urandom_range(0, 4))
               0: f3 = 3'd0;
               1: f3 = 3'd1;
               2: f3 = 3'd2;
               3: f3 = 3'd4;
               default: f3 = 3'd5;
            endcase
         end
         addr = ADDR_W'($urandom);
         if ($urandom_range(0, 5) == 0) addr = ADDR_W'(NBYTES - 4 + $urandom_range(0, 3));
         else if ($urandom_range(0, 3) == 0) addr = ADDR_W'($urandom_range(0, 63));
         do_req(we, f3, addr, $urandom);
         if ($urandom_range(0, 1) == 1) wait_done();
      end
      wait_done();
      repeat (3) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/lsu_mem_initiator.md
# lsu_mem_initiator

Load/store initiator between the core's execute stage and a word-wide, byte-enabled data memory. It accepts one RV32 load/store per handshake and issues aligned word transactions with byte enables. With misalignment support compiled in, it splits a misaligned access into two word transactions. It merges and extends load data and returns a single response.

## Interface
Parameters:
- ADDR_W, 13, byte-address width; the memory word address is ADDR_W-2 bits.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset; one clock, asynchronous, active-low.
- req_valid_i  in  1  core request valid.
- req_ready_o  out  1  block can accept a request; high only in IDLE.
- req_we_i  in  1  1 = store, 0 = load.
- req_funct3_i  in  3  RV32 funct3: LB/LH/LW/LBU/LHU = 0/1/2/4/5; SB/SH/SW = 0/1/2.
- req_addr_i  in  ADDR_W  byte address.
- req_wdata_i  in  32  store data, right-justified.
- rsp_valid_o  out  1  one-cycle response pulse.
- rsp_rdata_o  out  32  extended load data; 0 for stores and errors.
- rsp_err_o  out  1  illegal funct3, or misaligned access with the feature disabled.
- mem_req_o  out  1  memory request; held until granted.
- mem_gnt_i  in  1  memory grant.
- mem_we_o  out  1  write enable.
- mem_addr_o  out  ADDR_W-2  word address.
- mem_be_o  out  4  byte-lane enables; lane k = bits [8k+7:8k].
- mem_wdata_o  out  32  lane-positioned write data.
- mem_rvalid_i  in  1  read data valid; arrives at least 1 cycle after the grant.
- mem_rdata_i  in  32  read word.

## Operation
- Request latch: on req_valid_i && req_ready_o, capture we, funct3, addr and wdata.
- Access size: size = 1/2/4 bytes. off = addr[1:0]. Split when off+size > 4.
- Legality:
  - Loads with funct3 in {3,6,7} are illegal.
  - Stores with funct3 > 2 are illegal.
  - Illegal requests go to RESP with err=1 and produce no memory traffic.
- Store data: wide = {32'b0, wdata} << 8*off (64-bit).
  - Beat 0: lanes off..min(3, off+size-1), word addr[ADDR_W-1:2], data wide[31:0].
  - Beat 1: lanes 0..off+size-5, word addr+1, data wide[63:32].
- Word-address wrap: addr+1 wraps modulo 2^(ADDR_W-2).
- Loads: beat data is captured into a 64-bit buffer (beat 0 low, beat 1 high). Result = buffer >> 8*off.
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
- Load byte enables follow the same lane rule as stores; the memory ignores them on reads.
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
  - IDLE -> REQ0 on accept if legal; IDLE -> RESP if illegal.
  - REQ0 -> on mem_gnt_i: load -> WAIT0; store -> REQ1 if split, else RESP.
  - WAIT0 -> on mem_rvalid_i: REQ1 if split, else RESP.
  - REQ1 -> on mem_gnt_i: load -> WAIT1; store -> RESP.
  - WAIT1 -> RESP on mem_rvalid_i.
  - RESP -> IDLE unconditionally.
- mem_req_o is high only in REQ0/REQ1. mem_addr_o, mem_be_o, mem_we_o and mem_wdata_o are stable while mem_req_o is high.
- mem_rvalid_i is ignored outside WAIT0/WAIT1.

## Timing
- Reset values: state IDLE, rsp_valid_o 0, rsp_rdata_o 0, rsp_err_o 0, mem_req_o 0, mem_we_o 0, mem_be_o 0, mem_addr_o 0, mem_wdata_o 0. req_ready_o = 1 (IDLE).
- Aligned load with a zero-wait memory (grant in the request cycle, rvalid next cycle):
  - cycle 0: accept.
  - cycle 1: mem_req_o.
  - cycle 2: rvalid.
  - cycle 3: rsp_valid_o.
- Aligned store: accept c0, grant c1, rsp_valid_o c2.
- Split load: 5 cycles from accept to response with a zero-wait memory. Split store: 3 cycles.
- Illegal request: rsp_valid_o with rsp_err_o=1 the cycle after accept.
- Wait states stretch REQx/WAITx without limit; there is no timeout.
- Reset asserted mid-operation: FSM returns to IDLE asynchronously and mem_req_o drops immediately. A late mem_rvalid_i after reset release is ignored.
- A new request can be accepted the cycle after RESP, so back-to-back issue is limited only by this.

## Configuration
- LSU_MISALIGN_EN defined: misaligned accesses are split as above.
- LSU_MISALIGN_EN undefined: any access with off+size > 4 responds rsp_err_o=1 after 1 cycle, with no memory traffic. The beat-1 states and the 64-bit merge are not built.

## Test plan
- LW at 0x010, memory word 4 = 0x8899AABB, zero-wait -> mem_be_o=4'hF, mem_addr_o=4, rsp_rdata_o=0x8899AABB in cycle 3.
- SB 0x...A5 at 0x013 -> single beat, mem_be_o=4'h8, mem_wdata_o=0xA5000000, rsp_err_o=0.
- LH at 0x007 with words 1=0x80FFFFFF and 2=0x00000012 (misalign enabled) -> beats be=4'h8 then 4'h1, rsp_rdata_o=0x00001280.
- SW 0xDEADBEEF at 0x1FFE (ADDR_W=13) -> beat 0 word 0x7FF be=4'hC data 0xBEEF0000; beat 1 word 0x000 be=4'h3 data 0x0000DEAD.
- Load funct3=3 -> rsp_err_o=1 one cycle after accept, mem_req_o never asserted. Without LSU_MISALIGN_EN, LW at 0x001 gives the same response.
- Grant delayed 3 cycles and rst_ni pulsed during WAIT0 -> address/be stable while waiting, all outputs return to reset values, and a later rvalid produces no response.
